// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

    localparam int INST_W   = 32;
    localparam int PC_INC   = 4;
    localparam int PC_W_DEF = 32;

    // One prefetch queue slot: the instruction word and the PC it was fetched from.
    typedef struct packed {
        logic [PC_W_DEF-1:0] pc;
        logic [INST_W-1:0]   inst;
    } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_unit_queue.sv
// Prefetch queue: shift-style synchronous FIFO so the head slot is always a
// flop (mem[0]) and the decode-facing outputs are registered.
module fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     head_valid,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;

    entry_t          mem   [DEPTH];
    entry_t          mem_n [DEPTH];
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_n;
    logic [CW-1:0]   cnt_after_pop;
    logic            do_pop;
    logic            valid_q;

    // Next queue contents: flush wins, then pop shifts down, push lands behind the survivors.
    always_comb begin
        mem_n         = mem;
        cnt_n         = cnt_q;
        do_pop        = pop && (cnt_q != '0);
        cnt_after_pop = cnt_q - CW'(do_pop);
        if (flush) begin
            cnt_n = '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_n[i] = mem[i + 1];
                end
            end
            if (push && (cnt_after_pop < CW'(DEPTH))) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == cnt_after_pop) begin
                        mem_n[i] = push_data;
                    end
                end
                cnt_n = cnt_after_pop + CW'(1);
            end else begin
                cnt_n = cnt_after_pop;
            end
        end
    end

    // Occupancy and head-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_n;
            valid_q <= (cnt_n != '0);
        end
    end

    // Slot storage; contents are qualified by the count, so no reset needed.
    always_ff @(posedge clk) begin
        mem <= mem_n;
    end

    assign head_valid = valid_q;
    assign head       = mem[0];
    assign count      = cnt_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch front end: PC ownership, credit-limited pipelined
// requests, in-flight/discard tracking and a prefetch queue toward decode.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN adds a sticky fetch_misalign
// output that stops fetching after a redirect to a non-word-aligned target;
// without it the target's low two bits are cleared.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter int               QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0]  RESET_PC    = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          imem_req_valid,
    output logic [XLEN-1:0]               imem_req_addr,
    input  logic                          imem_req_ready,
    input  logic                          imem_rsp_valid,
    input  logic [INST_W-1:0]             imem_rsp_data,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          inst_valid,
    output logic [INST_W-1:0]             inst_data,
    output logic [XLEN-1:0]               inst_pc,
    input  logic                          inst_ready,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                          fetch_misalign
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_slot_t;

    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] rpc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   discard_cnt;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            rsp_push;
    logic            misalign_hold;
    logic [XLEN-1:0] redirect_target;
    fetch_slot_t     push_slot;
    fetch_slot_t     head_slot;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    // Sticky misalignment flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_hold   = misalign_q;
    assign fetch_misalign  = misalign_q;
    assign redirect_target = redirect_pc;
`else
    logic unused_pc_lsbs;

    assign misalign_hold   = 1'b0;
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_lsbs  = ^redirect_pc[1:0];
`endif

    // Every queued entry plus every outstanding response (even ones to be
    // discarded) holds a credit, so a response always finds a free slot.
    assign credit_used    = {1'b0, queue_count} + {1'b0, inflight};
    assign imem_req_valid = !rst && !redirect_valid && !misalign_hold
                            && (credit_used < (CW+1)'(QUEUE_DEPTH));
    assign imem_req_addr  = fpc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_push       = imem_rsp_valid && (discard_cnt == '0) && !redirect_valid;

    // PC registers plus outstanding/discard bookkeeping; redirect takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc         <= RESET_PC;
            rpc         <= RESET_PC;
            inflight    <= '0;
            discard_cnt <= '0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                fpc         <= redirect_target;
                rpc         <= redirect_target;
                discard_cnt <= inflight - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    fpc <= fpc + XLEN'(PC_INC);
                end
                if (imem_rsp_valid) begin
                    if (discard_cnt != '0) begin
                        discard_cnt <= discard_cnt - CW'(1);
                    end else begin
                        rpc <= rpc + XLEN'(PC_INC);
                    end
                end
            end
        end
    end

    assign push_slot.pc   = rpc;
    assign push_slot.inst = imem_rsp_data;

    fetch_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (fetch_slot_t)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (rsp_push),
        .push_data  (push_slot),
        .pop        (inst_ready && !redirect_valid),
        .flush      (redirect_valid),
        .head_valid (inst_valid),
        .head       (head_slot),
        .count      (queue_count)
    );

    assign inst_data = head_slot.inst;
    assign inst_pc   = head_slot.pc;

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Parametrised instruction-fetch front end for the next-generation MIPS core, replacing the single-cycle combinational `pc → instruction` path. Owns the PC, issues pipelined requests to an instruction memory with a valid/ready request channel and in-order responses of one or more cycles latency, and buffers returned instructions with their PC in a prefetch queue for decode. Branch, jump and `jr` targets from execute arrive as a redirect that flushes the queue and discards in-flight responses.

## Interface
- `XLEN`, 32, PC/address width (≥ 32)
- `QUEUE_DEPTH`, 4, prefetch queue entries; power of two, 2..16
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

- `clk` in 1, single clock; all logic rising-edge
- `rst` in 1, reset, synchronous, active-high
- `imem_req_valid` out 1, fetch request valid
- `imem_req_addr` out XLEN, word-aligned fetch address
- `imem_req_ready` in 1, memory accepts request
- `imem_rsp_valid` in 1, response valid (in order, ≥1 cycle after accept)
- `imem_rsp_data` in 32, instruction word
- `redirect_valid` in 1, branch/jump/jr taken
- `redirect_pc` in XLEN, new fetch target
- `inst_valid` out 1, queue head valid
- `inst_data` out 32, queue head instruction
- `inst_pc` out XLEN, queue head PC
- `inst_ready` in 1, decode consumes head
- `queue_count` out $clog2(QUEUE_DEPTH)+1, occupied entries

## Operation
- Fetch PC `fpc`; request accepted when `imem_req_valid && imem_req_ready`, then `fpc <= fpc + 4` (wraps modulo 2^XLEN).
- `inflight` counts accepted requests not yet responded (includes discards).
- Credit rule: `imem_req_valid = !redirect_valid && (queue_count + inflight < QUEUE_DEPTH)`; queue can never overflow.
- Response with `discard_cnt == 0`: push `{pc, data}`; pc taken from response-PC register `rpc`, then `rpc += 4`.
- Response with `discard_cnt > 0`: dropped, `discard_cnt -= 1`; `inflight` still decrements.
- Pop when `inst_valid && inst_ready`; push and pop in same cycle allowed, including at full (count unchanged) and empty (no bypass; pushed entry visible next cycle).
- Redirect (highest priority): queue flushed, `fpc <= rpc <= redirect_pc`, `discard_cnt <= inflight - imem_rsp_valid`; that cycle's response, if any, dropped; that cycle's pop ignored.
- `redirect_pc[1:0]` handling: see Configuration.

## Timing
- Reset values: `fpc = rpc = RESET_PC`, `inflight = discard_cnt = 0`, queue empty, `inst_valid = 0`, `queue_count = 0`, `imem_req_valid = 1` in first cycle after `rst` deasserts (0 while `rst` high).
- Reset mid-operation: all state cleared in the cycle `rst` is sampled; responses arriving afterwards for pre-reset requests are the memory's responsibility (memory shares `rst`).
- Response-to-`inst_valid`: 1 cycle. Redirect-to-new request: `imem_req_valid` with `redirect_pc` in the cycle after redirect.
- Steady state with 1-cycle memory and `inst_ready = 1`: one instruction per cycle.
- Combinational paths: `redirect_valid → imem_req_valid`, `queue_count/inflight → imem_req_valid` only; outputs `inst_*` are registered.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: adds output `fetch_misalign` (1 bit, reset 0); redirect with `redirect_pc[1:0] != 0` sets it sticky, flushes as normal, and holds `imem_req_valid = 0` until `rst`.
- Undefined: no extra port; `redirect_pc[1:0]` forced to 2'b00 when loaded.

## Structure
- Package `mips_fetch_pkg`: `fetch_entry_t` struct `{pc, inst}`, `INST_W = 32`, `PC_INC = 4`.
- One sub-module `fetch_queue`: synchronous FIFO of `fetch_entry_t`, depth `QUEUE_DEPTH`, push/pop/flush, count output; registered head.
- Top holds PC registers, credit, inflight/discard counters.

## Test plan
- Reset, 1-cycle memory, `inst_ready = 1` → `inst_pc` 0x0, 0x4, 0x8… on consecutive cycles from cycle 2.
- `inst_ready = 0`, QUEUE_DEPTH=4 → exactly 4 requests accepted, `queue_count = 4`, `imem_req_valid = 0` until a pop.
- 3-cycle memory, redirect to 0x100 with 2 in flight → both responses dropped, next `inst_pc = 0x100`.
- Redirect same cycle as response and pop at full → queue empty next cycle, response discarded, no extra decode consumption.
- `redirect_pc = 0x102`: macro off → fetch 0x100; macro on → `fetch_misalign = 1`, no further requests.
- `fpc = 32'hFFFF_FFFC` → following request address 0x0.
